class_vote_argmax: RTL and testbench
====================================

CLASS_VOTE_ARGMAX -- requirements
Module: class_vote_argmax

Interface
REQ-001 SHALL have parameter CLASSN, default 10: number of classes; valid range 2..64.
REQ-002 SHALL have parameter WEIGHT_W, default 9: width of each signed per-class clause weight.
REQ-003 SHALL have parameter SUM_W, default 18: width of each signed class accumulator; valid when SUM_W >= WEIGHT_W+1.
REQ-004 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-006 SHALL have port start, input, 1: clears all accumulators and opens a frame; honoured in IDLE only.
REQ-007 SHALL have port clause_valid, input, 1: a clause beat is present.
REQ-008 SHALL have port clause_ready, output, 1: the block accepts a beat.
REQ-009 SHALL have port clause_fire, input, 1: the clause output for this beat.
REQ-010 SHALL have port clause_last, input, 1: marks the final clause of the frame.
REQ-011 SHALL have port weight_in, input, CLASSN*WEIGHT_W: signed weights; class k at bits [k*WEIGHT_W +: WEIGHT_W].
REQ-012 SHALL have port result_valid, output, 1: class_op and max_sum are valid.
REQ-013 SHALL have port result_ready, input, 1: the consumer takes the result.
REQ-014 SHALL have port class_op, output, clog2(CLASSN): winning class index.
REQ-015 SHALL have port max_sum, output, SUM_W signed: the winning accumulator value.
REQ-016 SHALL have port busy, output, 1: the state is not IDLE.
REQ-017 SHALL have port ovf, output, 1: sticky per frame; any accumulator saturated.

Function
REQ-018 SHALL implement the FSM states IDLE, ACCUM, SCAN and DONE.
REQ-019 IDLE SHALL do the following: clause_ready=0; start=1 clears all accumulators and ovf, then moves to ACCUM next cycle.
REQ-020 ACCUM SHALL do the following: clause_ready=1; a beat is accepted when clause_valid and clause_ready are both 1.
REQ-021 On an accepted beat with clause_fire=1, the block SHALL perform, for every k in parallel, acc[k] <= sat(acc[k] + sext(w_k)).
REQ-022 On an accepted beat with clause_fire=0, the accumulators SHALL be unchanged.
REQ-023 sat() SHALL clamp to the range [-2^(SUM_W-1), 2^(SUM_W-1)-1] and SHALL set ovf whenever it clamps.
REQ-024 An accepted beat with clause_last=1 SHALL be applied, and the FSM SHALL then enter SCAN next cycle; clause_last with no handshake SHALL be ignored.
REQ-025 SCAN SHALL do the following: one class is compared per cycle, for CLASSN cycles; the first cycle loads best=acc[0] and idx=0; each later class replaces best only if strictly greater, so ties go to the lowest index.
REQ-026 Scan comparisons SHALL be signed, with no sentinel initial value, so all-negative sums resolve correctly.
REQ-027 Latency SHALL be as follows: last beat accepted in cycle T gives result_valid=1 in cycle T+1+CLASSN.
REQ-028 DONE SHALL do the following: result_valid=1, and class_op, max_sum and ovf are held stable until result_ready=1; the FSM then moves to IDLE next cycle and result_valid falls.
REQ-029 start SHALL be ignored in ACCUM, SCAN and DONE.
REQ-030 clause_ready SHALL be 0 in SCAN and DONE (backpressure upstream).
REQ-031 The accumulators SHALL retain their values after DONE until the next start.

Reset
REQ-032 rst=1 SHALL force the following at the next edge, from any state: state IDLE, all accumulators 0, ovf=0, result_valid=0, clause_ready=0, busy=0, class_op=0, max_sum=0.
REQ-033 rst SHALL take priority over start and over any handshake in the same cycle.

Verification (CLASSN=4, WEIGHT_W=9, SUM_W=12)
REQ-034 Basic: the bench SHALL drive beats fire=1 w={5,-3,2,0}; fire=0 w={100,100,100,100}; fire=1 last w={1,4,1,0} -> sums {6,1,3,0}, class_op=0, max_sum=6, result_valid exactly 5 cycles after the last beat.
REQ-035 Tie and negative: the bench SHALL drive sums {3,7,7,-2} -> class_op=1, max_sum=7; then sums {-5,-9,-1,-1} -> class_op=2, max_sum=-1.
REQ-036 Saturation: the bench SHALL drive 10 fired beats of w_0=+255 -> acc0=2047, ovf=1; 10 fired beats of w_1=-256 -> acc1=-2048.
REQ-037 Backpressure: the bench SHALL hold result_ready=0 for 5 DONE cycles with start pulsed -> outputs stable, clause_ready=0, start ignored; result_ready=1 -> IDLE next cycle.
REQ-038 Reset mid-ACCUM: the bench SHALL assert rst after 2 beats -> next cycle all outputs 0 and IDLE; a new frame with a single fired beat w={1,2,3,4} -> class_op=3, max_sum=4.
REQ-039 Stalled input: the bench SHALL drive clause_valid=0 gaps and clause_last with clause_valid=0 in ACCUM -> no accumulation, no state change.

Source files
------------

// File: rtl/class_vote_argmax.sv
// Clause-vote accumulator with a sequential signed argmax. Each fired clause adds its
// per-class weight with saturation; after the last clause the classes are scanned one per cycle.
module class_vote_argmax #(
  parameter int CLASSN   = 10,
  parameter int WEIGHT_W = 9,
  parameter int SUM_W    = 18
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        clause_valid,
  output logic                        clause_ready,
  input  logic                        clause_fire,
  input  logic                        clause_last,
  input  logic [CLASSN*WEIGHT_W-1:0]  weight_in,
  output logic                        result_valid,
  input  logic                        result_ready,
  output logic [$clog2(CLASSN)-1:0]   class_op,
  output logic signed [SUM_W-1:0]     max_sum,
  output logic                        busy,
  output logic                        ovf
);

  localparam int IDX_W = $clog2(CLASSN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CLASSN - 1);
  localparam logic signed [SUM_W-1:0] SUM_MAX = {1'b0, {(SUM_W-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] SUM_MIN = {1'b1, {(SUM_W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    SCAN,
    DONE
  } state_t;

  state_t                  state_q, state_d;
  logic signed [SUM_W-1:0] acc_q [CLASSN];
  logic signed [SUM_W-1:0] acc_d [CLASSN];
  logic                    ovf_q, ovf_d;
  logic [IDX_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic signed [SUM_W-1:0] best_q, best_d;

  logic signed [WEIGHT_W-1:0] w_k     [CLASSN];
  logic        [SUM_W:0]      raw_sum [CLASSN];
  logic signed [SUM_W-1:0]    sat_sum [CLASSN];
  logic [CLASSN-1:0]          sat_hit;
  logic                       beat;

  assign clause_ready = (state_q == ACCUM);
  assign result_valid = (state_q == DONE);
  assign busy         = (state_q != IDLE);
  assign ovf          = ovf_q;
  assign class_op     = idx_q;
  assign max_sum      = best_q;
  assign beat         = clause_valid && clause_ready;

  // One extra bit of headroom: a single add of a narrower weight can only overflow by one bit.
  always_comb begin
    for (int k = 0; k < CLASSN; k++) begin
      w_k[k]     = weight_in[k*WEIGHT_W +: WEIGHT_W];
      raw_sum[k] = {acc_q[k][SUM_W-1], acc_q[k]}
                 + {{(SUM_W+1-WEIGHT_W){w_k[k][WEIGHT_W-1]}}, w_k[k]};
      sat_hit[k] = raw_sum[k][SUM_W] != raw_sum[k][SUM_W-1];
      sat_sum[k] = raw_sum[k][SUM_W-1:0];
      if (sat_hit[k]) begin
        sat_sum[k] = raw_sum[k][SUM_W] ? SUM_MIN : SUM_MAX;
      end
    end
  end

  always_comb begin
    // NOTE: every next-state signal gets its hold value first so no path leaves one
    // unassigned; a missing default here would infer a latch.
    state_d = state_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    best_d  = best_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          for (int k = 0; k < CLASSN; k++) acc_d[k] = '0;
          ovf_d   = 1'b0;
          state_d = ACCUM;
        end
      end

      ACCUM: begin
        if (beat) begin
          if (clause_fire) begin
            acc_d = sat_sum;
            ovf_d = ovf_q | (|sat_hit);
          end
          if (clause_last) begin
            cnt_d   = '0;
            state_d = SCAN;
          end
        end
      end

      SCAN: begin
        // First class seeds the running best, so negative sums need no sentinel.
        if (cnt_q == '0) begin
          best_d = acc_q[0];
          idx_d  = '0;
        end else if (acc_q[cnt_q] > best_q) begin
          best_d = acc_q[cnt_q];
          idx_d  = cnt_q;
        end
        if (cnt_q == LAST_IDX) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      DONE: begin
        if (result_ready) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      // NOTE: the accumulator array is a handful of flops, not a RAM, so resetting it
      // costs nothing and keeps post-reset behaviour fully defined.
      for (int k = 0; k < CLASSN; k++) acc_q[k] <= '0;
      ovf_q  <= 1'b0;
      cnt_q  <= '0;
      idx_q  <= '0;
      best_q <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      best_q  <= best_d;
    end
  end

endmodule

// File: tb/tb_class_vote_argmax.sv
// Scoreboard bench for class_vote_argmax: the driver pushes model results, a negedge
// monitor pops and compares them at each result handshake.
module tb_class_vote_argmax;

  localparam int CLASSN   = 4;
  localparam int WEIGHT_W = 9;
  localparam int SUM_W    = 12;
  localparam int SMAX     = 2047;
  localparam int SMIN     = -2048;

  logic                       clk = 1'b0;
  logic                       rst;
  logic                       start;
  logic                       clause_valid;
  logic                       clause_ready;
  logic                       clause_fire;
  logic                       clause_last;
  logic [CLASSN*WEIGHT_W-1:0] weight_in;
  logic                       result_valid;
  logic                       result_ready;
  logic [1:0]                 class_op;
  logic signed [SUM_W-1:0]    max_sum;
  logic                       busy;
  logic                       ovf;

  class_vote_argmax #(.CLASSN(CLASSN), .WEIGHT_W(WEIGHT_W), .SUM_W(SUM_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .clause_valid(clause_valid),
    .clause_ready(clause_ready),
    .clause_fire (clause_fire),
    .clause_last (clause_last),
    .weight_in   (weight_in),
    .result_valid(result_valid),
    .result_ready(result_ready),
    .class_op    (class_op),
    .max_sum     (max_sum),
    .busy        (busy),
    .ovf         (ovf)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cls;
    int sum;
    int ovf;
    int cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t last_exp;
  int   n_checks = 0;
  int   n_fail   = 0;

  int m_acc[CLASSN];
  int m_ovf;

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [CLASSN*WEIGHT_W-1:0] pack4(input int a, input int b,
                                                        input int c, input int d);
    return {d[8:0], c[8:0], b[8:0], a[8:0]};
  endfunction

  function automatic int rw();
    return int'($urandom_range(511, 0)) - 256;
  endfunction

  function automatic void model_clear();
    for (int k = 0; k < CLASSN; k++) m_acc[k] = 0;
    m_ovf = 0;
  endfunction

  function automatic void model_add(input logic [CLASSN*WEIGHT_W-1:0] wv);
    for (int k = 0; k < CLASSN; k++) begin
      int s;
      s = m_acc[k] + int'($signed(wv[k*WEIGHT_W +: WEIGHT_W]));
      if (s > SMAX) begin s = SMAX; m_ovf = 1; end
      if (s < SMIN) begin s = SMIN; m_ovf = 1; end
      m_acc[k] = s;
    end
  endfunction

  function automatic void model_push(input int rise_cyc);
    exp_t e;
    e.cls = 0;
    e.sum = m_acc[0];
    for (int k = 1; k < CLASSN; k++) begin
      if (m_acc[k] > e.sum) begin
        e.sum = m_acc[k];
        e.cls = k;
      end
    end
    e.ovf = m_ovf;
    e.cyc = rise_cyc;
    last_exp = e;
    exp_q.push_back(e);
  endfunction

  // Monitor: records when result_valid rises and scores each accepted result.
  logic prev_valid = 1'b0;
  int   rise_cyc   = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (result_valid === 1'b1 && prev_valid !== 1'b1) rise_cyc = cyc;
      prev_valid = result_valid;
      if (result_valid === 1'b1 && result_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_result: got class_op=%0d max_sum=%0d, expected none",
                   class_op, max_sum);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("class_op", class_op, e.cls);
          check("max_sum", $signed(max_sum), e.sum);
          check("ovf", ovf, e.ovf);
          check("latency", rise_cyc, e.cyc);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, expected finish before timeout");
    $fatal(1, "watchdog");
  end

  // All driver tasks begin and end one time unit after a rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame();
    start = 1'b1;
    step();
    start = 1'b0;
    model_clear();
    check("start_to_accum", clause_ready, 1);
  endtask

  task automatic beat(input bit fire, input bit last, input logic [CLASSN*WEIGHT_W-1:0] wv);
    int waited = 0;
    clause_valid = 1'b1;
    clause_fire  = fire;
    clause_last  = last;
    weight_in    = wv;
    while (clause_ready !== 1'b1 && waited < 20) begin
      step();
      waited++;
    end
    if (clause_ready !== 1'b1) begin
      check("beat_ready", clause_ready, 1);
    end else begin
      if (fire) model_add(wv);
      if (last) model_push(cyc + 1 + CLASSN);
      step();
    end
    clause_valid = 1'b0;
    clause_fire  = 1'b0;
    clause_last  = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 100) begin
      step();
      n++;
    end
    check("return_idle", busy, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; clause_valid = 1'b0; clause_fire = 1'b0;
    clause_last = 1'b0; weight_in = '0; result_ready = 1'b1;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_ready", clause_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_valid", result_valid, 0);
    check("rst_class", class_op, 0);
    check("rst_sum", $signed(max_sum), 0);
    check("rst_ovf", ovf, 0);

    // Basic: sums {6,1,3,0}
    start_frame();
    beat(1, 0, pack4(5, -3, 2, 0));
    beat(0, 0, pack4(100, 100, 100, 100));
    beat(1, 1, pack4(1, 4, 1, 0));
    check("scan_ready_low", clause_ready, 0);
    wait_idle();

    // Ties resolve to the lowest index; all-negative sums
    start_frame();
    beat(1, 1, pack4(3, 7, 7, -2));
    wait_idle();
    start_frame();
    beat(1, 1, pack4(-5, -9, -1, -1));
    wait_idle();

    // Saturation both directions
    start_frame();
    for (int i = 0; i < 10; i++) beat(1, 0, pack4(255, 0, 0, 0));
    for (int i = 0; i < 10; i++) beat(1, i == 9, pack4(0, -256, 0, 0));
    wait_idle();
    start_frame();
    for (int i = 0; i < 10; i++) beat(1, i == 9, pack4(-256, -256, -256, -256));
    wait_idle();

    // Backpressure in DONE with a start pulse that must be ignored
    start_frame();
    beat(1, 0, pack4(10, 20, 30, 40));
    result_ready = 1'b0;
    beat(0, 1, pack4(rw(), rw(), rw(), rw()));
    begin
      int n = 0;
      while (result_valid !== 1'b1 && n < 50) begin step(); n++; end
    end
    check("bp_valid_rise", result_valid, 1);
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", result_valid, 1);
      check("bp_ready", clause_ready, 0);
      check("bp_busy", busy, 1);
      check("bp_class", class_op, last_exp.cls);
      check("bp_sum", $signed(max_sum), last_exp.sum);
      check("bp_ovf", ovf, last_exp.ovf);
      start = (i == 1);
      step();
      start = 1'b0;
    end
    result_ready = 1'b1;
    step();
    check("bp_idle_busy", busy, 0);
    check("bp_idle_valid", result_valid, 0);
    check("bp_idle_ready", clause_ready, 0);

    // Reset in the middle of a frame
    start_frame();
    beat(1, 0, pack4(rw(), rw(), rw(), rw()));
    beat(1, 0, pack4(rw(), rw(), rw(), rw()));
    rst = 1'b1;
    step();
    rst = 1'b0;
    model_clear();
    check("mid_rst_ready", clause_ready, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_valid", result_valid, 0);
    check("mid_rst_class", class_op, 0);
    check("mid_rst_sum", $signed(max_sum), 0);
    check("mid_rst_ovf", ovf, 0);
    start_frame();
    beat(1, 1, pack4(1, 2, 3, 4));
    wait_idle();

    // Stalled input: last/fire without valid must do nothing
    start_frame();
    beat(1, 0, pack4(rw(), rw(), rw(), rw()));
    for (int i = 0; i < 3; i++) begin
      clause_valid = 1'b0;
      clause_fire  = 1'b1;
      clause_last  = 1'b1;
      weight_in    = pack4(rw(), rw(), rw(), rw());
      step();
      check("stall_ready", clause_ready, 1);
      check("stall_valid", result_valid, 0);
    end
    clause_fire = 1'b0;
    clause_last = 1'b0;
    beat(1, 1, pack4(rw(), rw(), rw(), rw()));
    wait_idle();

    // Randomized frames with gaps and random fire
    for (int f = 0; f < 40; f++) begin
      int nb;
      nb = int'($urandom_range(8, 1));
      start_frame();
      for (int b = 0; b < nb; b++) begin
        int g;
        g = int'($urandom_range(2, 0));
        repeat (g) step();
        beat(($urandom_range(3, 0) != 0), b == nb - 1, pack4(rw(), rw(), rw(), rw()));
      end
      wait_idle();
    end

    repeat (3) step();
    check("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
